// File: rtl/chub_arbiter.sv
// chub_arbiter: credit-gated round-robin arbiter feeding the cluster hub sd_in port.
// Tracks free slots in the four leaf routers (destination = flit[1:0]) and only grants
// a requester whose target leaf has credit. The winning flit is registered onto sd_out.
// Optional build macro CHUB_ARB_PRIO_EN: requester 0 gets strict priority when eligible.
module chub_arbiter #(
    parameter int unsigned N_REQ    = 4,
    parameter int unsigned CRED_MAX = 4,
    parameter int unsigned CW       = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_REQ*20-1:0] req_flit,
    input  logic [N_REQ-1:0]    req_valid,
    output logic [N_REQ-1:0]    req_ready,
    input  logic [3:0]          cred_ret,
    output logic [19:0]         sd_out,
    output logic                sd_out_valid,
    output logic [4*CW-1:0]     cred_cnt,
    output logic                cred_err
);

    localparam int unsigned PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [CW-1:0] CredMax = CW'(CRED_MAX);

    logic [CW-1:0]    credit_q [4];
    logic [CW-1:0]    credit_d [4];
    logic [PW-1:0]    ptr_q, ptr_d;
    logic [19:0]      sd_out_q, sd_out_d;
    logic             sd_out_valid_q, sd_out_valid_d;
    logic             cred_err_q, cred_err_d;

    logic [N_REQ-1:0] elig;
    logic             gnt_found;
    logic             gnt_prio;
    logic [PW-1:0]    gnt_idx;
    logic [1:0]       gnt_dest;
    logic             xfer;
    logic [3:0]       dec;
    int               idx;

    // A requester is eligible only if its destination leaf has at least one free slot.
    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            elig[i] = req_valid[i] && (credit_q[req_flit[20*i +: 2]] != '0);
        end
    end

    // Pick the first eligible requester at or after ptr, wrapping; optional strict prio on 0.
    always_comb begin
        gnt_found = 1'b0;
        gnt_prio  = 1'b0;
        gnt_idx   = '0;
        idx       = 0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= int'(N_REQ)) begin
                idx = idx - int'(N_REQ);
            end
            if (!gnt_found && elig[idx[PW-1:0]]) begin
                gnt_found = 1'b1;
                gnt_idx   = idx[PW-1:0];
            end
        end
`ifdef CHUB_ARB_PRIO_EN
        if (elig[0]) begin
            gnt_found = 1'b1;
            gnt_prio  = 1'b1;
            gnt_idx   = '0;
        end
`endif
    end

    assign gnt_dest  = req_flit[20*int'(gnt_idx) +: 2];
    // Reset masks the grant so nothing is accepted while the hub path is being cleared.
    assign xfer      = gnt_found && !rst;
    assign req_ready = xfer ? ({{(N_REQ-1){1'b0}}, 1'b1} << gnt_idx) : '0;

    // Next-state: register the winning flit, advance ptr, and balance grants vs returns.
    always_comb begin
        ptr_d          = ptr_q;
        sd_out_d       = sd_out_q;
        sd_out_valid_d = 1'b0;
        cred_err_d     = cred_err_q;
        dec            = '0;
        if (xfer) begin
            sd_out_d       = req_flit[20*int'(gnt_idx) +: 20];
            sd_out_valid_d = 1'b1;
            if (!gnt_prio) begin
                ptr_d = (gnt_idx == PW'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
            end
        end
        for (int j = 0; j < 4; j++) begin
            dec[j]      = xfer && (gnt_dest == 2'(j));
            credit_d[j] = credit_q[j];
            if (dec[j] && !cred_ret[j]) begin
                credit_d[j] = credit_q[j] - 1'b1;
            end else if (!dec[j] && cred_ret[j]) begin
                // Saturate on a spurious return and flag it rather than wrapping.
                if (credit_q[j] == CredMax) begin
                    cred_err_d = 1'b1;
                end else begin
                    credit_d[j] = credit_q[j] + 1'b1;
                end
            end
        end
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int j = 0; j < 4; j++) begin
                credit_q[j] <= CredMax;
            end
            ptr_q          <= '0;
            sd_out_q       <= '0;
            sd_out_valid_q <= 1'b0;
            cred_err_q     <= 1'b0;
        end else begin
            for (int j = 0; j < 4; j++) begin
                credit_q[j] <= credit_d[j];
            end
            ptr_q          <= ptr_d;
            sd_out_q       <= sd_out_d;
            sd_out_valid_q <= sd_out_valid_d;
            cred_err_q     <= cred_err_d;
        end
    end

    // Pack per-leaf credit counters onto the flat output bus.
    always_comb begin
        cred_cnt = '0;
        for (int j = 0; j < 4; j++) begin
            cred_cnt[CW*j +: CW] = credit_q[j];
        end
    end

    assign sd_out       = sd_out_q;
    assign sd_out_valid = sd_out_valid_q;
    assign cred_err     = cred_err_q;

endmodule

// File: tb/tb_chub_arbiter.sv
// Directed bench for chub_arbiter: each step states the expected grant, a scoreboard
// queue carries the expected registered flit to the following cycle.
module tb_chub_arbiter;

    localparam int N  = 4;
    localparam int CW = 3;

    logic            clk = 1'b0;
    logic            rst;
    logic [N*20-1:0] req_flit;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [3:0]      cred_ret;
    logic [19:0]     sd_out;
    logic            sd_out_valid;
    logic [4*CW-1:0] cred_cnt;
    logic            cred_err;

    int total = 0;
    int bad   = 0;

    int         seq  [N];
    logic [1:0] dest [N];

    typedef struct {
        logic        v;
        logic [19:0] f;
    } sb_t;
    sb_t sbq[$];

    int fair_g [8];
    int exh_g  [13] = '{1, 3, 1, 3, 1, 3, 1, 3, 3, 3, 1, 3, 3};
    int exh_r  [13] = '{-1, -1, 0, -1, 0, -1, 0, -1, 0, 2, 0, -1, -1};
    int prio_g [4];

    chub_arbiter #(.N_REQ(4), .CRED_MAX(4), .CW(3)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_flit     (req_flit),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .cred_ret     (cred_ret),
        .sd_out       (sd_out),
        .sd_out_valid (sd_out_valid),
        .cred_cnt     (cred_cnt),
        .cred_err     (cred_err)
    );

    always #5 clk = ~clk;

    function automatic logic [19:0] mk_flit(input int i);
        return {4'hA, 4'(i), 10'(seq[i]), dest[i]};
    endfunction

    task automatic drive_flits();
        for (int i = 0; i < N; i++) begin
            req_flit[20*i +: 20] = mk_flit(i);
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_cred(input string tag, input int j, input int exp);
        chk(tag, 32'(cred_cnt[CW*j +: CW]), 32'(exp));
    endtask

    // One clock: check the combinational grant, queue the expected flit, check it after the edge.
    task automatic step(input int g, input string tag);
        sb_t          it;
        logic [N-1:0] exp_rdy;
        drive_flits();
        #3;
        exp_rdy = (g >= 0) ? (4'b0001 << g) : 4'b0000;
        chk({tag, "_rdy"}, 32'(req_ready), 32'(exp_rdy));
        it.v = (g >= 0);
        it.f = (g >= 0) ? mk_flit(g) : 20'h0;
        sbq.push_back(it);
        @(posedge clk);
        #1;
        cred_ret = 4'b0000;
        it = sbq.pop_front();
        chk({tag, "_vld"}, 32'(sd_out_valid), 32'(it.v));
        if (it.v) begin
            chk({tag, "_flit"}, 32'(sd_out), 32'(it.f));
            seq[g]++;
        end
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        step(-1, tag);
        step(-1, tag);
        for (int j = 0; j < 4; j++) begin
            chk_cred({tag, "_cred"}, j, 4);
        end
        chk({tag, "_sd_out"}, 32'(sd_out), 32'h0);
        chk({tag, "_err"}, 32'(cred_err), 32'h0);
        rst = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            seq[i]  = 0;
            dest[i] = 2'(i);
        end
`ifdef CHUB_ARB_PRIO_EN
        fair_g = '{0, 0, 0, 0, 0, 0, 0, 0};
        prio_g = '{0, 0, 0, 0};
`else
        fair_g = '{0, 1, 2, 3, 0, 1, 2, 3};
        prio_g = '{2, 0, 2, 0};
`endif
        cred_ret  = 4'b0000;
        req_valid = 4'b1111;
        drive_flits();

        // Reset with all requesters valid: ready must stay low.
        do_reset("reset");

        // Round-robin over four requesters, each to its own leaf, credit returned next cycle.
        for (int k = 0; k < 8; k++) begin
            if (k > 0) cred_ret = 4'b0001 << fair_g[k-1];
            step(fair_g[k], "fair");
        end
        req_valid = 4'b0000;
        cred_ret  = 4'b0001 << fair_g[7];
        step(-1, "fair_idle");
        for (int j = 0; j < 4; j++) begin
            chk_cred("fair_cred", j, 4);
        end

        // Requester 1 drains leaf 2; requester 3 keeps flowing to leaf 0.
        dest[1]   = 2'd2;
        dest[3]   = 2'd0;
        req_valid = 4'b1010;
        for (int k = 0; k < 13; k++) begin
            if (exh_r[k] >= 0) cred_ret = 4'b0001 << exh_r[k];
            step(exh_g[k], "exh");
            if (k == 7) chk_cred("exh_leaf2_empty", 2, 0);
            if (k == 8) chk_cred("exh_leaf0_same", 0, 3);
        end
        chk_cred("exh_leaf2_end", 2, 0);
        chk_cred("exh_leaf0_end", 0, 1);
        req_valid = 4'b0000;
        do_reset("reset2");

        // Grant to leaf 1 together with a leaf 1 return leaves the count unchanged.
        dest[1]   = 2'd1;
        req_valid = 4'b0010;
        step(1, "sim_a");
        chk_cred("sim_a_cred", 1, 3);
        cred_ret = 4'b0010;
        step(1, "sim_b");
        chk_cred("sim_b_cred", 1, 3);
        req_valid = 4'b0000;
        cred_ret  = 4'b0010;
        step(-1, "sim_c");
        chk_cred("sim_c_cred", 1, 4);

        // Return into a full counter saturates and raises the sticky error.
        cred_ret = 4'b0001;
        step(-1, "ovf");
        chk_cred("ovf_cred", 0, 4);
        chk("ovf_err", 32'(cred_err), 32'h1);
        step(-1, "ovf_hold");
        chk("ovf_err_sticky", 32'(cred_err), 32'h1);
        do_reset("reset3");

        // Move ptr to 2, then requesters 0 and 2 contend.
        req_valid = 4'b0010;
        step(1, "prio_setup");
        dest[0]   = 2'd0;
        dest[2]   = 2'd2;
        req_valid = 4'b0101;
        cred_ret  = 4'b0010;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) cred_ret = 4'b0001 << prio_g[k-1];
            step(prio_g[k], "prio");
        end
        req_valid = 4'b0000;
        step(-1, "end_idle");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/chub_arbiter.md
# chub_arbiter

Credit-gated round-robin arbiter that shares the single `sd_in` port of a cluster hub among N_REQ upstream requesters (crossbar output ports and local injectors). It tracks free buffer slots in each of the four leaf routers, using destination field `flit[1:0]`. A flit is granted only when its target leaf has credit. The granted flit is registered onto the hub input with a one-cycle valid pulse, so the hub never forwards into a full leaf.

## Interface
- `N_REQ`, 4: number of requesters (2..8).
- `CRED_MAX`, 4: per-leaf buffer depth; the reset credit value (1..7).
- `CW`, 3: credit counter width; must satisfy `CRED_MAX < 2**CW`.

- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_flit`  in  N_REQ*20  flit of requester i at bits [20*i+19:20*i]; destination leaf is bits [20*i+1:20*i].
- `req_valid`  in  N_REQ  requester i has a flit.
- `req_ready`  out  N_REQ  one-hot grant, combinational, same cycle.
- `cred_ret`  in  4  one-cycle pulse per leaf when that leaf frees one slot.
- `sd_out`  out  20  flit to the hub `sd_in`.
- `sd_out_valid`  out  1  flit valid, to the hub `sd_in_valid`.
- `cred_cnt`  out  4*CW  current credits, leaf j at bits [CW*j+CW-1:CW*j].
- `cred_err`  out  1  sticky flag; set by a credit return into a full counter.

## Operation
- **Eligibility.** `elig[i] = req_valid[i] && credit[dest_i] != 0`.
- **Round-robin selection.**
  - Search starts at pointer `ptr` and wraps modulo N_REQ.
  - The first eligible index is the grant `g`.
  - Assert `req_ready[g]`; all other `req_ready` bits are 0.
  - At most one grant per cycle.
  - With no eligible requester, `req_ready` is all zeros.
- **Transfer.** A transfer occurs when `req_valid[g] && req_ready[g]`. On the next edge:
  - `sd_out <= req_flit[g]`
  - `sd_out_valid <= 1`
  - `ptr <= (g+1) mod N_REQ`
  - decrement `credit[dest_g]`
  - In a cycle without a transfer: `sd_out_valid <= 0`, `sd_out` holds its value, `ptr` holds.
- **Credit return.**
  - `cred_ret[j]` increments `credit[j]`.
  - A grant to leaf j and `cred_ret[j]` in the same cycle leave `credit[j]` unchanged.
  - A return while `credit[j] == CRED_MAX` with no same-cycle grant to j: the counter stays at CRED_MAX and `cred_err` is set.
  - Counters never wrap.
  - Returns to several leaves in one cycle are all applied.
- **Requester contract.** `req_flit[i]` is stable while `req_valid[i] && !req_ready[i]`. Dropping `req_valid` without a grant is allowed.
- **Head-of-line blocking.** A requester whose destination has zero credit is skipped. It does not block other requesters.
- **Reset (`rst` = 1 at an edge).** Sets:
  - every `credit[j]` to CRED_MAX
  - `ptr` to 0
  - `sd_out` to 20'b0
  - `sd_out_valid` to 0
  - `cred_err` to 0
  - During reset `req_ready` is forced to 0.
  - Reset mid-stream discards any in-flight flit. `sd_out_valid` is 0 on the cycle after the reset edge.

## Timing
- Grant decision is combinational from `req_valid`, `req_flit[1:0]`, `credit` and `ptr`. It has no path from `sd_out`.
- Latency from accepted request to `sd_out_valid` is 1 cycle. Throughput is one flit per cycle while credits last.
- Credit returned in cycle t is usable for arbitration in cycle t+1.
- The `cred_cnt` and `cred_err` outputs are registered.

## Configuration
- `CHUB_ARB_PRIO_EN` defined:
  - Requester 0 has strict priority whenever `elig[0]` is 1, regardless of `ptr`.
  - A priority grant to requester 0 does not update `ptr`.
  - When `elig[0]` is 0, round-robin runs over all requesters as above.
- `CHUB_ARB_PRIO_EN` undefined: pure round-robin over all N_REQ requesters.

## Test plan
- **Reset.** Assert `rst` for 2 cycles.
  - Every `cred_cnt` field = 4, `sd_out` = 0, `sd_out_valid` = 0, `req_ready` = 0, `cred_err` = 0.
- **Round-robin fairness.** All 4 requesters valid continuously, each with a different destination, `cred_ret` pulsed each cycle after a grant.
  - Grants occur in order 0,1,2,3,0,… and `sd_out` matches each flit one cycle later.
- **Credit exhaustion.** Requester 1 streams to leaf 2 with no returns.
  - Exactly 4 grants, then `req_ready[1]` = 0 and `cred_cnt` leaf 2 = 0.
  - A single `cred_ret[2]` pulse yields exactly one further grant.
  - Meanwhile requester 3, targeting leaf 0, keeps being granted.
- **Simultaneous events.** Grant to leaf 1 and `cred_ret[1]` in the same cycle: the leaf 1 count is unchanged.
- **Overflow.** `cred_ret[0]` pulsed with leaf 0 at 4: count stays at 4 and `cred_err` = 1 until the next reset.
- **Priority, `CHUB_ARB_PRIO_EN` defined.** Requesters 0 and 2 continuously valid, `ptr` = 2: requester 0 is granted every cycle.
  - Without the macro, the same stimulus alternates grants 2,0,2,0.
